// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared command/state encodings and default widths for the counter timer
package counter_ctrl_pkg;
  localparam int W_DEF = 32;
  localparam int WRAP_W_DEF = 16;
  typedef enum logic [1:0] {START_ONESHOT, START_PERIODIC, STOP, RESUME} cmd_op_e;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} ctrl_state_e;
endpackage

// File: rtl/counter_core.sv
// counter_core: W-bit up-counter with clear priority over enable, sync active-low reset
module counter_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    count <= !rst ? '0 : clr ? '0 : en ? count + W'(1) : count;
endmodule

// File: rtl/counter_timer_ctrl.sv
// counter_timer_ctrl: valid/ready command sequencer owning a one-shot/periodic up-counter with expire, tally and sticky irq
module counter_timer_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [W-1:0]      cmd_period,
  output logic              cmd_err,
  output logic [W-1:0]      count,
  output logic              busy,
  output logic              expire,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              irq,
  input  logic              irq_ack
);
  ctrl_state_e state, nxt;
  cmd_op_e     op;
  logic [W-1:0] period;
  logic oneshot, accept, start, start_ok, terminal;
  assign op       = cmd_op_e'(cmd_op);
  assign accept   = cmd_valid & cmd_ready;
  assign start    = accept & (op == START_ONESHOT || op == START_PERIODIC);
  assign start_ok = start & |cmd_period;
  assign terminal = state == RUN && count == period - W'(1);
  assign busy     = state == RUN;
  always_comb
    nxt = start_ok                                ? RUN   :
          accept && op == STOP && state == RUN     ? PAUSE :
          accept && op == RESUME && state == PAUSE ? RUN   :
          terminal && oneshot                      ? IDLE  : state;
  counter_core #(.W(W)) u_core (
    .clk  (clk),
    .rst  (rst),
    .en   (state == RUN),
    .clr  (start_ok | terminal),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      period     <= '0;
      oneshot    <= 1'b0;
      cmd_ready  <= 1'b0;
      cmd_err    <= 1'b0;
      expire     <= 1'b0;
      wrap_count <= '0;
      irq        <= 1'b0;
    end else begin
      state      <= nxt;
      cmd_ready  <= !accept;
      cmd_err    <= start & ~|cmd_period;
      expire     <= terminal;
      irq        <= terminal | (irq & !irq_ack);
      wrap_count <= terminal ? (&wrap_count ? wrap_count : wrap_count + WRAP_W'(1)) :
                    start_ok ? '0 : wrap_count;
      if (start_ok) begin
        period  <= cmd_period;
        oneshot <= op == START_ONESHOT;
      end
    end
  end
endmodule
